dcache_miss_ctrl: RTL and testbench



---
 rtl/dcache_miss_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_ctrl
// Purpose  : Miss/flush sequencer for the set-associative data cache.
//            Runs multi-word write-backs, fills and coherence upgrades
//            between the cache arrays and the bus/coherence controller.
//            On halt it walks every set and way, writes back dirty blocks
//            and then raises flushed.
// Ports    : CLK/nRST          clock, asynchronous active-low reset
//            halt/enable/...   core request and array lookup results
//            cache_*           array index/way/offset select
//            load_data ...     array write strobes
//            dREN/dWEN/daddr/dstore, cctrans/ccwrite, mem_ready  bus side
//            hit_count         hit statistic, written out after flush
//            flushed           flush complete
// Options  : DCACHE_HIT_COUNT_WRITE_EN - after the flush walk, write
//            hit_count to address 0x3100 before entering HALTED.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dcache_miss_ctrl #(
    parameter  int SETS  = 8,
    parameter  int WAYS  = 2,
    parameter  int WORDS = 2,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int OFF_W = $clog2(WORDS),
    localparam int TAG_W = 30 - IDX_W - OFF_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             halt,
    input  logic             enable,
    input  logic [31:0]      dmemaddr,
    input  logic             will_modify,
    input  logic             hit,
    input  logic             hit_dirty,
    input  logic [WAY_W-1:0] victim_way,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             rd_dirty,
    input  logic [31:0]      rd_data,
    output logic [IDX_W-1:0] cache_idx,
    output logic [WAY_W-1:0] cache_way,
    output logic [OFF_W-1:0] cache_off,
    output logic             load_data,
    output logic             set_valid,
    output logic             write_tag,
    output logic             clear_dirty,
    output logic             inv_complete,
    output logic             dREN,
    output logic             dWEN,
    output logic [31:0]      daddr,
    output logic [31:0]      dstore,
    output logic             cctrans,
    output logic             ccwrite,
    input  logic             mem_ready,
    input  logic [31:0]      hit_count,
    output logic             flushed
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WB       = 4'd1,
        S_FILL     = 4'd2,
        S_UPGRADE  = 4'd3,
        S_WAIT_HIT = 4'd4,
        S_FL_CHECK = 4'd5,
        S_FL_WB    = 4'd6,
        S_HALTED   = 4'd7
`ifdef DCACHE_HIT_COUNT_WRITE_EN
        , S_HIT_WR = 4'd8
`endif
    } state_t;

`ifdef DCACHE_HIT_COUNT_WRITE_EN
    localparam state_t c_FLUSH_DONE = S_HIT_WR;
    wire w_unused_bits = ^dmemaddr[1:0];
`else
    localparam state_t c_FLUSH_DONE = S_HALTED;
    wire w_unused_bits = ^{dmemaddr[1:0], hit_count};
`endif

    localparam logic [OFF_W-1:0] c_LAST_WORD = OFF_W'(WORDS - 1);
    localparam logic [WAY_W-1:0] c_LAST_WAY  = WAY_W'(WAYS - 1);
    localparam logic [IDX_W-1:0] c_LAST_SET  = IDX_W'(SETS - 1);

    state_t           r_state, w_next_state;
    logic [OFF_W-1:0] r_word_cnt;
    logic [IDX_W-1:0] r_set_cnt;
    logic [WAY_W-1:0] r_way_cnt;
    logic [WAY_W-1:0] r_vway;

    // Fields of the core address
    wire [TAG_W-1:0] w_addr_tag = dmemaddr[31 -: TAG_W];
    wire [IDX_W-1:0] w_addr_idx = dmemaddr[2+OFF_W +: IDX_W];
    wire [OFF_W-1:0] w_addr_off = dmemaddr[2 +: OFF_W];

    wire w_last_word = (r_word_cnt == c_LAST_WORD);
    wire w_beat_done = mem_ready && w_last_word;
    wire w_flush_end = (r_way_cnt == c_LAST_WAY) && (r_set_cnt == c_LAST_SET);

    logic w_word_inc;    // current beat accepted, step to next word
    logic w_burst_done;  // last beat accepted, rewind word counter
    logic w_advance;     // flush walk moves to the next way/set

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_set_cnt  <= '0;
            r_way_cnt  <= '0;
            r_vway     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_burst_done)
                r_word_cnt <= '0;
            else if (w_word_inc)
                r_word_cnt <= r_word_cnt + 1'b1;
            if (w_advance) begin
                if (r_way_cnt == c_LAST_WAY) begin
                    r_way_cnt <= '0;
                    r_set_cnt <= r_set_cnt + 1'b1;
                end else begin
                    r_way_cnt <= r_way_cnt + 1'b1;
                end
            end
            // The LRU victim may change once the fill updates LRU, so the
            // way being serviced is frozen for the whole transaction.
            if (r_state == S_IDLE && w_next_state != S_IDLE)
                r_vway <= victim_way;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cache_idx    = w_addr_idx;
        cache_way    = victim_way;
        cache_off    = w_addr_off;
        load_data    = 1'b0;
        set_valid    = 1'b0;
        write_tag    = 1'b0;
        clear_dirty  = 1'b0;
        inv_complete = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = '0;
        dstore       = '0;
        cctrans      = 1'b0;
        ccwrite      = 1'b0;
        flushed      = 1'b0;
        w_word_inc   = 1'b0;
        w_burst_done = 1'b0;
        w_advance    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (halt)
                    w_next_state = S_FL_CHECK;
                else if (!enable)
                    w_next_state = S_IDLE;
                else if (!hit && rd_dirty)
                    w_next_state = S_WB;
                else if (!hit)
                    w_next_state = S_FILL;
                else if (will_modify && !hit_dirty)
                    w_next_state = S_UPGRADE;
            end
            S_WB: begin
                cache_off  = r_word_cnt;
                cache_way  = r_vway;
                dWEN       = 1'b1;
                cctrans    = 1'b1;
                daddr      = {rd_tag, w_addr_idx, r_word_cnt, 2'b00};
                dstore     = rd_data;
                w_word_inc = mem_ready;
                if (w_beat_done) begin
                    clear_dirty  = 1'b1;
                    w_burst_done = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            S_FILL, S_UPGRADE: begin
                cache_off  = r_word_cnt;
                cache_way  = r_vway;
                dREN       = 1'b1;
                cctrans    = 1'b1;
                daddr      = {w_addr_tag, w_addr_idx, r_word_cnt, 2'b00};
                w_word_inc = mem_ready;
                if (r_state == S_FILL) begin
                    ccwrite   = will_modify;
                    load_data = mem_ready;
                    set_valid = w_beat_done;
                    write_tag = w_beat_done;
                end else begin
                    // Upgrade only gains exclusivity; the data already held is kept.
                    ccwrite      = 1'b1;
                    inv_complete = w_beat_done;
                end
                if (w_beat_done) begin
                    w_burst_done = 1'b1;
                    w_next_state = S_WAIT_HIT;
                end
            end
            S_WAIT_HIT: begin
                cache_way = r_vway;
                if (hit)
                    w_next_state = S_IDLE;
            end
            S_FL_CHECK: begin
                cache_idx = r_set_cnt;
                cache_way = r_way_cnt;
                cache_off = r_word_cnt;
                if (rd_dirty) begin
                    w_next_state = S_FL_WB;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = w_flush_end ? c_FLUSH_DONE : S_FL_CHECK;
                end
            end
            S_FL_WB: begin
                cache_idx  = r_set_cnt;
                cache_way  = r_way_cnt;
                cache_off  = r_word_cnt;
                dWEN       = 1'b1;
                cctrans    = 1'b1;
                daddr      = {rd_tag, r_set_cnt, r_word_cnt, 2'b00};
                dstore     = rd_data;
                w_word_inc = mem_ready;
                if (w_beat_done) begin
                    clear_dirty  = 1'b1;
                    w_burst_done = 1'b1;
                    w_advance    = 1'b1;
                    w_next_state = w_flush_end ? c_FLUSH_DONE : S_FL_CHECK;
                end
            end
`ifdef DCACHE_HIT_COUNT_WRITE_EN
            S_HIT_WR: begin
                cache_idx = r_set_cnt;
                cache_way = r_way_cnt;
                dWEN      = 1'b1;
                cctrans   = 1'b1;
                daddr     = 32'h0000_3100;
                dstore    = hit_count;
                if (mem_ready)
                    w_next_state = S_HALTED;
            end
`endif
            S_HALTED: begin
                cache_idx = r_set_cnt;
                cache_way = r_way_cnt;
                flushed   = 1'b1;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_ctrl
// Purpose  : Directed self-checking bench for dcache_miss_ctrl. Instance u_dut
//            uses default geometry (8 sets, 2 ways, 2 words); u_dut4 uses
//            16 sets, 2 ways, 4 words for the slow-bus burst case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt, enable, enable2, will_modify, hit, hit_dirty;
    logic [31:0] dmemaddr, rd_data, hit_count;
    logic [0:0]  victim_way;
    logic [25:0] rd_tag;
    logic        rd_dirty_drv, mem_ready;
    logic        fl_mode, blk_clean;
    wire         rd_dirty;
    wire  [23:0] rd_tag2 = rd_tag[23:0];
    logic        c_zero = 1'b0;

    // default instance outputs
    logic [2:0]  cache_idx;
    logic [0:0]  cache_way;
    logic [0:0]  cache_off;
    logic        load_data, set_valid, write_tag, clear_dirty, inv_complete;
    logic        dREN, dWEN, cctrans, ccwrite, flushed;
    logic [31:0] daddr, dstore;

    // wide-block instance outputs
    logic [3:0]  cache_idx2;
    logic [0:0]  cache_way2;
    logic [1:0]  cache_off2;
    logic        load_data2, set_valid2, write_tag2, clear_dirty2, inv_complete2;
    logic        dREN2, dWEN2, cctrans2, ccwrite2, flushed2;
    logic [31:0] daddr2, dstore2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // Array model for the flush: only set 5 / way 1 is dirty until written back.
    assign rd_dirty = fl_mode ? (cache_idx == 3'd5 && cache_way == 1'b1 && !blk_clean)
                              : rd_dirty_drv;
    always @(posedge CLK) begin
        if (!fl_mode)
            blk_clean <= 1'b0;
        else if (clear_dirty)
            blk_clean <= 1'b1;
    end

    dcache_miss_ctrl u_dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .enable(enable), .dmemaddr(dmemaddr),
        .will_modify(will_modify), .hit(hit), .hit_dirty(hit_dirty),
        .victim_way(victim_way), .rd_tag(rd_tag), .rd_dirty(rd_dirty), .rd_data(rd_data),
        .cache_idx(cache_idx), .cache_way(cache_way), .cache_off(cache_off),
        .load_data(load_data), .set_valid(set_valid), .write_tag(write_tag),
        .clear_dirty(clear_dirty), .inv_complete(inv_complete), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
        .mem_ready(mem_ready), .hit_count(hit_count), .flushed(flushed)
    );

    dcache_miss_ctrl #(.SETS(16), .WAYS(2), .WORDS(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .halt(c_zero), .enable(enable2), .dmemaddr(dmemaddr),
        .will_modify(will_modify), .hit(hit), .hit_dirty(hit_dirty),
        .victim_way(victim_way), .rd_tag(rd_tag2), .rd_dirty(rd_dirty), .rd_data(rd_data),
        .cache_idx(cache_idx2), .cache_way(cache_way2), .cache_off(cache_off2),
        .load_data(load_data2), .set_valid(set_valid2), .write_tag(write_tag2),
        .clear_dirty(clear_dirty2), .inv_complete(inv_complete2), .dREN(dREN2), .dWEN(dWEN2),
        .daddr(daddr2), .dstore(dstore2), .cctrans(cctrans2), .ccwrite(ccwrite2),
        .mem_ready(mem_ready), .hit_count(hit_count), .flushed(flushed2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int inv_cnt, beats, ticks, wbeats, hcw, exp_ticks;

        nRST = 1'b0; halt = 1'b0; enable = 1'b0; enable2 = 1'b0; will_modify = 1'b0;
        hit = 1'b0; hit_dirty = 1'b0; dmemaddr = 32'h98; rd_data = '0; hit_count = '0;
        victim_way = 1'b0; rd_tag = '0; rd_dirty_drv = 1'b0; mem_ready = 1'b0; fl_mode = 1'b0;

        // ---------------- reset state
        tick(); tick();
        at_neg();
        check("rst dREN", dREN, 0);
        check("rst dWEN", dWEN, 0);
        check("rst cctrans", cctrans, 0);
        check("rst daddr", daddr, 0);
        check("rst flushed", flushed, 0);
        check("rst cache_idx passthru", cache_idx, 3);
        nRST = 1'b1;
        tick();

        // ---------------- clean read miss at 0x40
        dmemaddr = 32'h40; enable = 1'b1; mem_ready = 1'b1;
        at_neg(); check("t1 idle dREN", dREN, 0); tick();
        at_neg();
        check("t1 b0 dREN", dREN, 1);
        check("t1 b0 daddr", daddr, 32'h40);
        check("t1 b0 load", load_data, 1);
        check("t1 b0 set_valid", set_valid, 0);
        check("t1 b0 cctrans", cctrans, 1);
        check("t1 b0 ccwrite", ccwrite, 0);
        tick();
        at_neg();
        check("t1 b1 daddr", daddr, 32'h44);
        check("t1 b1 load", load_data, 1);
        check("t1 b1 set_valid", set_valid, 1);
        check("t1 b1 write_tag", write_tag, 1);
        tick();
        at_neg();
        check("t1 wait dREN", dREN, 0);
        check("t1 wait load", load_data, 0);
        hit = 1'b1;
        tick();
        at_neg();
        check("t1 idle dREN", dREN, 0);
        enable = 1'b0; hit = 1'b0;
        tick();

        // ---------------- dirty victim, tag 0x123, idx 3
        dmemaddr = 32'h98; enable = 1'b1; rd_dirty_drv = 1'b1; victim_way = 1'b1;
        rd_tag = 26'h123; rd_data = 32'hDEAD_0001;
        at_neg(); check("t2 idle way", cache_way, 1); tick();
        victim_way = 1'b0;
        at_neg();
        check("t2 wb0 dWEN", dWEN, 1);
        check("t2 wb0 daddr", daddr, 32'h48D8);
        check("t2 wb0 dstore", dstore, 32'hDEAD_0001);
        check("t2 wb0 way", cache_way, 1);
        check("t2 wb0 clear", clear_dirty, 0);
        tick();
        at_neg();
        check("t2 wb1 daddr", daddr, 32'h48DC);
        check("t2 wb1 off", cache_off, 1);
        check("t2 wb1 clear", clear_dirty, 1);
        rd_dirty_drv = 1'b0;
        tick();
        at_neg();
        check("t2 f0 dWEN", dWEN, 0);
        check("t2 f0 dREN", dREN, 1);
        check("t2 f0 daddr", daddr, 32'h98);
        tick();
        at_neg();
        check("t2 f1 daddr", daddr, 32'h9C);
        check("t2 f1 set_valid", set_valid, 1);
        tick();
        hit = 1'b1;
        tick();
        enable = 1'b0; hit = 1'b0;
        tick();

        // ---------------- store hit to clean line -> upgrade
        dmemaddr = 32'h40; enable = 1'b1; hit = 1'b1; will_modify = 1'b1; hit_dirty = 1'b0;
        inv_cnt = 0;
        at_neg(); check("t3 idle dREN", dREN, 0); tick();
        at_neg();
        check("t3 u0 dREN", dREN, 1);
        check("t3 u0 ccwrite", ccwrite, 1);
        check("t3 u0 load", load_data, 0);
        check("t3 u0 daddr", daddr, 32'h40);
        if (inv_complete) inv_cnt++;
        tick();
        at_neg();
        check("t3 u1 daddr", daddr, 32'h44);
        check("t3 u1 load", load_data, 0);
        check("t3 u1 set_valid", set_valid, 0);
        if (inv_complete) inv_cnt++;
        tick();
        at_neg();
        check("t3 wait dREN", dREN, 0);
        if (inv_complete) inv_cnt++;
        check("t3 inv pulses", inv_cnt, 1);
        enable = 1'b0;
        tick();
        hit = 1'b0; will_modify = 1'b0;
        tick();

        // ---------------- 4-word block, 16 sets, slow bus
        dmemaddr = 32'h1230; enable2 = 1'b1; mem_ready = 1'b0;
        at_neg(); check("t5 idle dREN", dREN2, 0); tick();
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            mem_ready = (c % 3 == 2);
            at_neg();
            check("t5 daddr", daddr2, 32'h1230 + 4 * beats);
            check("t5 off", cache_off2, beats);
            check("t5 load", load_data2, mem_ready);
            check("t5 set_valid", set_valid2, (mem_ready && beats == 3));
            if (mem_ready) beats++;
            tick();
        end
        at_neg();
        check("t5 beats", beats, 4);
        check("t5 wait dREN", dREN2, 0);
        hit = 1'b1; enable2 = 1'b0; mem_ready = 1'b1;
        tick();
        hit = 1'b0;
        tick();

        // ---------------- flush with only set 5 / way 1 dirty
        fl_mode = 1'b1; halt = 1'b1; rd_tag = 26'h55; rd_data = 32'hCAFE_0001;
        hit_count = 32'd77; mem_ready = 1'b1;
        ticks = 0; wbeats = 0; hcw = 0;
        while (!flushed && ticks < 60) begin
            at_neg();
            if (dWEN && mem_ready) begin
                if (daddr == 32'h3100) begin
                    check("t4 hitcnt data", dstore, 32'd77);
                    hcw++;
                end else begin
                    check("t4 wb daddr", daddr, 32'h1568 + 4 * wbeats);
                    check("t4 wb dstore", dstore, 32'hCAFE_0001);
                    wbeats++;
                end
            end
            tick();
            ticks++;
        end
`ifdef DCACHE_HIT_COUNT_WRITE_EN
        exp_ticks = 20;
        check("t4 hitcnt writes", hcw, 1);
`else
        exp_ticks = 19;
        check("t4 hitcnt writes", hcw, 0);
`endif
        at_neg();
        check("t4 flushed", flushed, 1);
        check("t4 cycles", ticks, exp_ticks);
        check("t4 wb beats", wbeats, 2);
        halt = 1'b0; fl_mode = 1'b0;
        tick(); tick(); tick();
        at_neg();
        check("t4 halted sticky", flushed, 1);
        check("t4 halted dWEN", dWEN, 0);

        // ---------------- reset during a fill
        nRST = 1'b0;
        tick();
        at_neg();
        nRST = 1'b1;
        dmemaddr = 32'h40; enable = 1'b1; hit = 1'b0; rd_dirty_drv = 1'b0; mem_ready = 1'b1;
        tick();
        at_neg(); check("t6 b0 daddr", daddr, 32'h40); tick();
        mem_ready = 1'b0;
        at_neg();
        check("t6 b1 daddr", daddr, 32'h44);
        #1 nRST = 1'b0;
        #1;
        check("t6 rst dREN", dREN, 0);
        check("t6 rst cctrans", cctrans, 0);
        check("t6 rst daddr", daddr, 0);
        check("t6 rst flushed", flushed, 0);
        tick();
        at_neg();
        nRST = 1'b1; mem_ready = 1'b1;
        tick();
        at_neg();
        check("t6 restart dREN", dREN, 1);
        check("t6 restart daddr", daddr, 32'h40);
        check("t6 restart off", cache_off, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
